sid_dca_sched: RTL and testbench

- Time-multiplexed digitally-controlled-amplifier engine for the SID core.
- Replaces three per-voice wave×envelope multipliers with one pipelined signed multiplier, shared round-robin between voices 0..2.
- Each ce_1m tick it snapshots all voice waveforms and envelopes, sequences them through the multiplier, and commits the three scaled voice samples together.
- Sits between the voice/envelope generators and the filter/mixer, on the fast system clock.

---
 rtl/sid_pkg.sv | 41 ++++
 rtl/sid_dca_sched_if.sv | 46 ++++
 rtl/sid_mul_pipe.sv | 54 +++++
 rtl/sid_dca_sched.sv | 187 ++++++++++++++++++
 tb/tb_sid_dca_sched.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sid_pkg.sv
// Shared definitions for the SID DCA scheduler: widths, slot count, FSM states,
// operand payload and the offset-binary to two's-complement wave conversion.
// Optional feature macro: SID_DCA_EXT_EN (adds a fourth, external slot).
package sid_pkg;

    localparam int unsigned WAVE_W     = 12;
    localparam int unsigned ENV_W      = 8;
    localparam int unsigned OPND_A_W   = 13;
    localparam int unsigned OPND_B_W   = 9;
    localparam int unsigned PROD_W     = 20;
    localparam int unsigned VOICE_W    = 14;
    localparam int unsigned FRAC_SHIFT = 6;
    localparam int unsigned TAG_W      = 2;

`ifdef SID_DCA_EXT_EN
    localparam int unsigned NSLOT = 4;
`else
    localparam int unsigned NSLOT = 3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_COMMIT
    } sid_state_e;

    typedef logic [TAG_W-1:0] sid_tag_t;

    // One multiplier job: signed sample and unsigned gain.
    typedef struct packed {
        logic [WAVE_W-1:0] sample;
        logic [ENV_W-1:0]  gain;
    } sid_operand_t;

    // Offset-binary wave to two's complement: flipping the MSB subtracts 2048.
    function automatic logic [WAVE_W-1:0] wave_to_signed(input logic [WAVE_W-1:0] w);
        return {~w[WAVE_W-1], w[WAVE_W-2:0]};
    endfunction

endpackage

// File: rtl/sid_dca_sched_if.sv
// Voice-side bus of the DCA scheduler.
// slave  : the scheduler (consumes ce_1m/wave/env, produces voice/status).
// master : the voice/envelope side and mixer that connect to it.
// ce_1m, wave0..2, env0..2 -> scheduler; voice0..2, out_valid, busy, overrun <- scheduler.
// With SID_DCA_EXT_EN: ext_in, ext_gain -> scheduler; voice_ext <- scheduler.
interface sid_dca_sched_if;
    import sid_pkg::*;

    logic               ce_1m;
    logic [WAVE_W-1:0]  wave0;
    logic [WAVE_W-1:0]  wave1;
    logic [WAVE_W-1:0]  wave2;
    logic [ENV_W-1:0]   env0;
    logic [ENV_W-1:0]   env1;
    logic [ENV_W-1:0]   env2;
    logic [VOICE_W-1:0] voice0;
    logic [VOICE_W-1:0] voice1;
    logic [VOICE_W-1:0] voice2;
    logic               out_valid;
    logic               busy;
    logic               overrun;
`ifdef SID_DCA_EXT_EN
    logic [WAVE_W-1:0]  ext_in;
    logic [ENV_W-1:0]   ext_gain;
    logic [VOICE_W-1:0] voice_ext;
`endif

    modport slave (
        input  ce_1m, wave0, wave1, wave2, env0, env1, env2,
`ifdef SID_DCA_EXT_EN
        input  ext_in, ext_gain,
        output voice_ext,
`endif
        output voice0, voice1, voice2, out_valid, busy, overrun
    );

    modport master (
        output ce_1m, wave0, wave1, wave2, env0, env1, env2,
`ifdef SID_DCA_EXT_EN
        output ext_in, ext_gain,
        input  voice_ext,
`endif
        input  voice0, voice1, voice2, out_valid, busy, overrun
    );

endinterface

// File: rtl/sid_mul_pipe.sv
// 13x9 signed multiplier with LAT register stages; tag and valid travel with the
// product. result is the product scaled by 2^-6 (arithmetic floor).
// Ports: clock, reset, a, b, in_valid, in_tag -> result, out_valid, out_tag.
module sid_mul_pipe
    import sid_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [OPND_A_W-1:0] a,
    input  logic signed [OPND_B_W-1:0] b,
    input  logic                       in_valid,
    input  sid_tag_t                   in_tag,
    output logic signed [VOICE_W-1:0]  result,
    output logic                       out_valid,
    output sid_tag_t                   out_tag
);

    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod_q [LAT];
    sid_tag_t                 tag_q  [LAT];
    logic [LAT-1:0]           valid_q;

    // Operands are sign-extended to the product width before multiplying.
    assign prod_c = PROD_W'(a) * PROD_W'(b);

    // Valid sideband is the only state that needs clearing.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int unsigned i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Product and tag shift along with valid.
    always_ff @(posedge clock) begin
        prod_q[0] <= prod_c;
        tag_q[0]  <= in_tag;
        for (int unsigned i = 1; i < LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
            tag_q[i]  <= tag_q[i-1];
        end
    end

    assign result    = VOICE_W'(prod_q[LAT-1] >>> FRAC_SHIFT);
    assign out_valid = valid_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];

endmodule

// File: rtl/sid_dca_sched.sv
// Time-multiplexed DCA: on each ce_1m snapshots all voice wave/envelope pairs,
// runs them through one shared multiplier and commits all voices together.
// Ports: clock, reset (sync, active-high), bus (sid_dca_sched_if.slave).
// Parameter MUL_LAT: multiplier depth, 1..3.
// Optional feature macro: SID_DCA_EXT_EN adds an external slot (voice_ext).
module sid_dca_sched
    import sid_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic            clock,
    input  logic            reset,
    sid_dca_sched_if.slave  bus
);

    sid_state_e   state_q, state_d;
    sid_tag_t     slot_q, slot_d;
    logic         capture_c;
    logic         issue_c;
    logic         commit_c;
    logic         overrun_set_c;

    sid_operand_t in_op_c  [NSLOT];
    sid_operand_t snap_q   [NSLOT];
    sid_operand_t issue_op_c;

    logic signed [OPND_A_W-1:0] mul_a_c;
    logic signed [OPND_B_W-1:0] mul_b_c;
    logic signed [VOICE_W-1:0]  mul_result;
    logic                       mul_valid;
    sid_tag_t                   mul_tag;

    logic signed [VOICE_W-1:0]  res_q   [NSLOT];
    logic signed [VOICE_W-1:0]  voice_q [NSLOT];
    logic                       out_valid_q;
    logic                       busy_q;
    logic                       overrun_q;

    // Live operands, converted to signed samples ready for capture.
    always_comb begin
        in_op_c[0] = '{sample: wave_to_signed(bus.wave0), gain: bus.env0};
        in_op_c[1] = '{sample: wave_to_signed(bus.wave1), gain: bus.env1};
        in_op_c[2] = '{sample: wave_to_signed(bus.wave2), gain: bus.env2};
`ifdef SID_DCA_EXT_EN
        // External sample is already two's complement.
        in_op_c[3] = '{sample: bus.ext_in, gain: bus.ext_gain};
`endif
    end

    // Next-state and control decode.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        capture_c     = 1'b0;
        issue_c       = 1'b0;
        commit_c      = 1'b0;
        overrun_set_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ce_1m) begin
                    capture_c = 1'b1;
                    slot_d    = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue_c       = 1'b1;
                overrun_set_c = bus.ce_1m;
                slot_d        = slot_q + 2'd1;
                if (slot_q == sid_tag_t'(NSLOT - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                overrun_set_c = bus.ce_1m;
                // Tags leave in issue order, so the last tag closes the sequence.
                if (mul_valid && mul_tag == sid_tag_t'(NSLOT - 1)) begin
                    commit_c = 1'b1;
                    state_d  = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (bus.ce_1m) begin
                    capture_c = 1'b1;
                    slot_d    = '0;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Snapshot registers; only written on an accepted ce_1m.
    always_ff @(posedge clock) begin
        if (capture_c) begin
            snap_q <= in_op_c;
        end
    end

    // Operand select for the slot being issued.
    always_comb begin
        issue_op_c = snap_q[0];
        for (int unsigned k = 0; k < NSLOT; k++) begin
            if (slot_q == sid_tag_t'(k)) begin
                issue_op_c = snap_q[k];
            end
        end
    end

    assign mul_a_c = {issue_op_c.sample[WAVE_W-1], issue_op_c.sample};
    assign mul_b_c = {1'b0, issue_op_c.gain};

    sid_mul_pipe #(
        .LAT (MUL_LAT)
    ) u_mul (
        .clock     (clock),
        .reset     (reset),
        .a         (mul_a_c),
        .b         (mul_b_c),
        .in_valid  (issue_c),
        .in_tag    (slot_q),
        .result    (mul_result),
        .out_valid (mul_valid),
        .out_tag   (mul_tag)
    );

    // Tagged results land in their slot register as they leave the pipe.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                if (mul_valid && mul_tag == sid_tag_t'(k)) begin
                    res_q[k] <= mul_result;
                end
            end
        end
    end

    // Output registers; the last slot bypasses its result register so the
    // commit is visible in the COMMIT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                voice_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= commit_c;
            busy_q      <= (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
            overrun_q   <= overrun_q | overrun_set_c;
            if (commit_c) begin
                for (int unsigned k = 0; k < NSLOT; k++) begin
                    voice_q[k] <= (mul_valid && mul_tag == sid_tag_t'(k)) ? mul_result : res_q[k];
                end
            end
        end
    end

    assign bus.voice0    = voice_q[0];
    assign bus.voice1    = voice_q[1];
    assign bus.voice2    = voice_q[2];
`ifdef SID_DCA_EXT_EN
    assign bus.voice_ext = voice_q[3];
`endif
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sid_dca_sched.sv
// Randomized bench for sid_dca_sched against a transaction-level schedule model.
module tb_sid_dca_sched;
    import sid_pkg::*;

    localparam int unsigned MUL_LAT = 2;
    localparam int          LAT     = int'(NSLOT) + int'(MUL_LAT) + 1;

    logic clock;
    logic reset;

    sid_dca_sched_if bus();

    sid_dca_sched #(
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors;
    int checks;
    int cyc;

    // Stimulus values applied on the next step.
    logic [11:0] w_in [3];
    logic [7:0]  e_in [3];
    logic [11:0] x_in;
    logic [7:0]  g_in;

    // Model: one pending sequence at most, committing at accept cycle + LAT.
    bit pend;
    int commit_at;
    int pend_v [4];
    int exp_v  [4];
    bit exp_ov;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int scale(input int s, input int g);
        int p;
        p = s * g;
        return p >>> 6;
    endfunction

    task automatic model_reset();
        pend   = 1'b0;
        exp_ov = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_v[k]  = 0;
            pend_v[k] = 0;
        end
    endtask

    // One clock cycle: apply inputs, check outputs, advance the model.
    task automatic step(input bit ce, input bit rst);
        bit ev;
        @(posedge clock);
        #1;
        reset      = rst;
        bus.ce_1m  = ce;
        bus.wave0  = w_in[0];
        bus.wave1  = w_in[1];
        bus.wave2  = w_in[2];
        bus.env0   = e_in[0];
        bus.env1   = e_in[1];
        bus.env2   = e_in[2];
`ifdef SID_DCA_EXT_EN
        bus.ext_in   = x_in;
        bus.ext_gain = g_in;
`endif
        @(negedge clock);
        ev = 1'b0;
        if (pend && commit_at == cyc) begin
            ev = 1'b1;
            exp_v = pend_v;
            pend = 1'b0;
        end
        check_eq("out_valid", bus.out_valid, ev);
        check_eq("busy", bus.busy, pend);
        check_eq("overrun", bus.overrun, exp_ov);
        check_eq("voice0", $signed(bus.voice0), exp_v[0]);
        check_eq("voice1", $signed(bus.voice1), exp_v[1]);
        check_eq("voice2", $signed(bus.voice2), exp_v[2]);
`ifdef SID_DCA_EXT_EN
        check_eq("voice_ext", $signed(bus.voice_ext), exp_v[3]);
`endif
        if (rst) begin
            model_reset();
        end else if (ce) begin
            if (pend) begin
                exp_ov = 1'b1;
            end else begin
                pend      = 1'b1;
                commit_at = cyc + LAT;
                for (int k = 0; k < 3; k++) begin
                    pend_v[k] = scale(int'(w_in[k]) - 2048, int'(e_in[k]));
                end
                pend_v[3] = (NSLOT == 4) ? scale(int'($signed(x_in)), int'(g_in)) : 0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    function automatic logic [11:0] rand_wave();
        logic [11:0] b [4];
        b[0] = 12'h000; b[1] = 12'h800; b[2] = 12'hFFF; b[3] = 12'h7FF;
        if ($urandom_range(3) == 0) return b[$urandom_range(3)];
        return 12'($urandom);
    endfunction

    function automatic logic [7:0] rand_env();
        if ($urandom_range(3) == 0) return ($urandom_range(1) == 0) ? 8'd0 : 8'd255;
        return 8'($urandom);
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        for (int k = 0; k < 3; k++) begin
            w_in[k] = '0;
            e_in[k] = '0;
        end
        x_in = '0;
        g_in = '0;
        reset = 1'b1;
        bus.ce_1m = 1'b0;
        bus.wave0 = '0; bus.wave1 = '0; bus.wave2 = '0;
        bus.env0  = '0; bus.env1  = '0; bus.env2  = '0;
`ifdef SID_DCA_EXT_EN
        bus.ext_in = '0; bus.ext_gain = '0;
`endif
        repeat (2) @(posedge clock);
        model_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        idle(2);

        // Boundary waves at full envelope.
        w_in[0] = 12'h000; w_in[1] = 12'h800; w_in[2] = 12'hFFF;
        e_in[0] = 8'd255;  e_in[1] = 8'd255;  e_in[2] = 8'd255;
        x_in = 12'h800; g_in = 8'd128;
        step(1'b1, 1'b0);
        idle(9);

        // Zero envelope, input changes after capture must not leak in.
        w_in[0] = 12'hFFF; e_in[0] = 8'd0;
        step(1'b1, 1'b0);
        idle(1);
        w_in[0] = 12'h000; e_in[0] = 8'd255;
        idle(8);

        // Overrun during ISSUE, then sticky until reset.
        w_in[1] = 12'h123; e_in[1] = 8'd77;
        step(1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0);
        idle(10);
        step(1'b0, 1'b1);
        idle(2);

        // Back-to-back: second ce_1m lands in the COMMIT cycle.
        step(1'b1, 1'b0);
        idle(LAT - 1);
        w_in[2] = 12'h456; e_in[2] = 8'd200;
        step(1'b1, 1'b0);
        idle(9);

        // Reset mid-sequence, then a clean sequence.
        step(1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1);
        idle(2);
        w_in[0] = 12'hABC; e_in[0] = 8'd31;
        step(1'b1, 1'b0);
        idle(9);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++) begin
                w_in[k] = rand_wave();
                e_in[k] = rand_env();
            end
            x_in = rand_wave();
            g_in = rand_env();
            step($urandom_range(5) == 0, $urandom_range(199) == 0);
        end
        step(1'b0, 1'b1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
